// File: rtl/pbus_pkg.sv
// Shared encodings for the processor-bus arbiter.
// Bus op codes, FSM states and arbitration modes.
package pbus_pkg;

  localparam logic [1:0] PRW_IDLE  = 2'b00;
  localparam logic [1:0] PRW_READ  = 2'b01;
  localparam logic [1:0] PRW_WRITE = 2'b10;

  typedef enum logic [1:0] {
    S_IDLE,
    S_STROBE,
    S_WAIT,
    S_RESP
  } state_e;

  localparam int ARB_FIXED = 0;
  localparam int ARB_RR    = 1;

endpackage

// File: rtl/pbus_arbiter_rr_picker.sv
// Winner selection for the bus arbiter.
// Picks the first set request at or after the start index.
module rr_picker #(
  parameter int N  = 2,
  parameter int IW = 1
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] ptr_i,
  input  logic          rr_i,
  output logic [IW-1:0] idx_o,
  output logic          vld_o
);

  assign vld_o = |req_i;

  // smallest circular distance from the start index wins
  always_comb begin
    int s;
    int d;
    int best;
    s     = rr_i ? int'(ptr_i) : 0;
    best  = N;
    d     = 0;
    idx_o = '0;
    for (int m = 0; m < N; m++) begin
      d = (m >= s) ? (m - s) : (m - s + N);
      if (req_i[m] && d < best) begin
        best  = d;
        idx_o = IW'(m);
      end
    end
  end

endmodule

// File: rtl/pbus_arbiter.sv
// Multi-requester master for the PStrobe/PReady bus.
// One transaction at a time: strobe, wait, respond.
module pbus_arbiter
  import pbus_pkg::*;
#(
  parameter int N_REQ    = 2,
  parameter int AW       = 16,
  parameter int DW       = 32,
  parameter int ARB_MODE = 0,
  parameter int TIMEOUT  = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N_REQ-1:0]  req,
  input  logic [2*N_REQ-1:0] req_rw,
  input  logic [3*N_REQ-1:0] req_f3,
  input  logic [AW*N_REQ-1:0] req_addr,
  input  logic [DW*N_REQ-1:0] req_wdata,
  output logic [N_REQ-1:0]  ack,
  output logic [N_REQ-1:0]  err,
  output logic [N_REQ-1:0]  stall,
  output logic [DW-1:0]     rdata,
  output logic              PStrobe,
  output logic [1:0]        PRW,
  output logic [2:0]        PF3,
  output logic [AW-1:0]     PAddress,
  output logic [DW-1:0]     PWData,
  output logic              PDataOE,
  input  logic [DW-1:0]     PRData,
  input  logic              PReady
);

  localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [N_REQ-1:0] ONE = N_REQ'(1);
  localparam logic [IW-1:0] LAST = IW'(N_REQ - 1);

  state_e          state_q;
  logic [IW-1:0]   win_q;
  logic [IW-1:0]   rr_q;
  logic [CW-1:0]   cnt_q;
  logic            strobe_q;
  logic [1:0]      prw_q;
  logic            oe_q;
  logic [2:0]      f3_q;
  logic [AW-1:0]   addr_q;
  logic [DW-1:0]   wd_q;
  logic [DW-1:0]   rdata_q;
  logic [N_REQ-1:0] ack_q;
  logic [N_REQ-1:0] err_q;

  logic [IW-1:0]   pick_idx;
  logic            pick_vld;
  logic [1:0]      rw_d;
  logic [2:0]      f3_d;
  logic [AW-1:0]   addr_d;
  logic [DW-1:0]   wd_d;

  rr_picker #(
    .N  (N_REQ),
    .IW (IW)
  ) u_pick (
    .req_i (req),
    .ptr_i (rr_q),
    .rr_i  (ARB_MODE == ARB_RR),
    .idx_o (pick_idx),
    .vld_o (pick_vld)
  );

  // mux the winning requester's fields; unknown ops become reads
  always_comb begin
    logic [1:0] op;
    op     = PRW_READ;
    f3_d   = '0;
    addr_d = '0;
    wd_d   = '0;
    for (int m = 0; m < N_REQ; m++) begin
      if (pick_idx == IW'(m)) begin
        op     = req_rw[m*2 +: 2];
        f3_d   = req_f3[m*3 +: 3];
        addr_d = req_addr[m*AW +: AW];
        wd_d   = req_wdata[m*DW +: DW];
      end
    end
    rw_d = (op == PRW_WRITE) ? PRW_WRITE : PRW_READ;
  end

  // transaction FSM with all bus and response outputs registered
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      win_q    <= '0;
      rr_q     <= '0;
      cnt_q    <= '0;
      strobe_q <= 1'b0;
      prw_q    <= PRW_IDLE;
      oe_q     <= 1'b0;
      f3_q     <= '0;
      addr_q   <= '0;
      wd_q     <= '0;
      rdata_q  <= '0;
      ack_q    <= '0;
      err_q    <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (pick_vld) begin
            win_q    <= pick_idx;
            strobe_q <= 1'b1;
            prw_q    <= rw_d;
            oe_q     <= (rw_d == PRW_WRITE);
            f3_q     <= f3_d;
            addr_q   <= addr_d;
            wd_q     <= wd_d;
            state_q  <= S_STROBE;
          end
        end
        S_STROBE: begin
          strobe_q <= 1'b0;
          cnt_q    <= '0;
          state_q  <= S_WAIT;
        end
        S_WAIT: begin
          if (PReady) begin
            if (prw_q == PRW_READ) rdata_q <= PRData;
            ack_q   <= ONE << win_q;
            prw_q   <= PRW_IDLE;
            oe_q    <= 1'b0;
            state_q <= S_RESP;
          end else if (cnt_q == CW'(TIMEOUT - 1)) begin
            ack_q   <= ONE << win_q;
            err_q   <= ONE << win_q;
            prw_q   <= PRW_IDLE;
            oe_q    <= 1'b0;
            state_q <= S_RESP;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        S_RESP: begin
          ack_q <= '0;
          err_q <= '0;
          if (ARB_MODE == ARB_RR) begin
            rr_q <= (win_q == LAST) ? '0 : win_q + 1'b1;
          end
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign ack      = ack_q;
  assign err      = err_q;
  assign stall    = req & ~ack_q;
  assign rdata    = rdata_q;
  assign PStrobe  = strobe_q;
  assign PRW      = prw_q;
  assign PF3      = f3_q;
  assign PAddress = addr_q;
  assign PWData   = wd_q;
  assign PDataOE  = oe_q;

endmodule

// File: tb/tb_pbus_arbiter.sv
// Bench for pbus_arbiter: fixed-priority and round-robin instances.
// Transaction-level model checked every cycle plus directed literals.
module tb_pbus_arbiter;

  localparam int TO = 8;

  logic clk = 1'b0;
  logic rst;
  logic prdy;
  logic [31:0] prd;

  always #5 clk = ~clk;

  // instance 0: two requesters, fixed priority
  logic [1:0]  r0;
  logic [3:0]  rw0;
  logic [5:0]  f30;
  logic [31:0] ad0;
  logic [63:0] wd0;
  logic [1:0]  ack0, err0, st0;
  logic [31:0] rd0, pw0;
  logic        pst0, poe0;
  logic [1:0]  prw0;
  logic [2:0]  pf0;
  logic [15:0] pa0;

  // instance 1: three requesters, round-robin
  logic [2:0]  r1;
  logic [5:0]  rw1;
  logic [8:0]  f31;
  logic [47:0] ad1;
  logic [95:0] wd1;
  logic [2:0]  ack1, err1, st1;
  logic [31:0] rd1, pw1;
  logic        pst1, poe1;
  logic [1:0]  prw1;
  logic [2:0]  pf1;
  logic [15:0] pa1;

  pbus_arbiter #(
    .N_REQ(2), .AW(16), .DW(32), .ARB_MODE(0), .TIMEOUT(TO)
  ) dut0 (
    .clk(clk), .rst(rst), .req(r0), .req_rw(rw0), .req_f3(f30),
    .req_addr(ad0), .req_wdata(wd0), .ack(ack0), .err(err0),
    .stall(st0), .rdata(rd0), .PStrobe(pst0), .PRW(prw0), .PF3(pf0),
    .PAddress(pa0), .PWData(pw0), .PDataOE(poe0), .PRData(prd),
    .PReady(prdy)
  );

  pbus_arbiter #(
    .N_REQ(3), .AW(16), .DW(32), .ARB_MODE(1), .TIMEOUT(TO)
  ) dut1 (
    .clk(clk), .rst(rst), .req(r1), .req_rw(rw1), .req_f3(f31),
    .req_addr(ad1), .req_wdata(wd1), .ack(ack1), .err(err1),
    .stall(st1), .rdata(rd1), .PStrobe(pst1), .PRW(prw1), .PF3(pf1),
    .PAddress(pa1), .PWData(pw1), .PDataOE(poe1), .PRData(prd),
    .PReady(prdy)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [95:0] act,
                     input logic [95:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // model: m_t = -1 respond, 0 no transaction, 1 strobe, >=2 waiting
  int          m_t[2];
  int          m_win[2];
  int          m_ptr[2];
  logic [2:0]  e_ack[2];
  logic [2:0]  e_err[2];
  logic        e_str[2];
  logic        e_oe[2];
  logic [1:0]  e_prw[2];
  logic [2:0]  e_f3[2];
  logic [15:0] e_ad[2];
  logic [31:0] e_wd[2];
  logic [31:0] e_rd[2];

  function automatic int nreq(input int k);
    return (k == 0) ? 2 : 3;
  endfunction

  task automatic model_reset(input int k);
    m_t[k] = 0; m_win[k] = 0; m_ptr[k] = 0;
    e_ack[k] = '0; e_err[k] = '0; e_str[k] = 1'b0; e_oe[k] = 1'b0;
    e_prw[k] = '0; e_f3[k] = '0; e_ad[k] = '0; e_wd[k] = '0;
    e_rd[k] = '0;
  endtask

  task automatic step(
    input int k, input logic [2:0] rq, input logic [5:0] rw,
    input logic [8:0] f3, input logic [47:0] ad, input logic [95:0] wd,
    input logic [2:0] ack, input logic [2:0] err, input logic [2:0] st,
    input logic [31:0] rd, input logic pst, input logic [1:0] prw,
    input logic [2:0] pf, input logic [15:0] pa, input logic [31:0] pw,
    input logic poe
  );
    string tg;
    tg = (k == 0) ? "fp" : "rr";
    if (rst) model_reset(k);
    chk({tg, ".ack"},   96'(ack), 96'(e_ack[k]));
    chk({tg, ".err"},   96'(err), 96'(e_err[k]));
    chk({tg, ".stall"}, 96'(st),  96'(rq & ~e_ack[k]));
    chk({tg, ".rdata"}, 96'(rd),  96'(e_rd[k]));
    chk({tg, ".PStrobe"}, 96'(pst), 96'(e_str[k]));
    chk({tg, ".PRW"},   96'(prw), 96'(e_prw[k]));
    chk({tg, ".PF3"},   96'(pf),  96'(e_f3[k]));
    chk({tg, ".PAddress"}, 96'(pa), 96'(e_ad[k]));
    chk({tg, ".PWData"}, 96'(pw), 96'(e_wd[k]));
    chk({tg, ".PDataOE"}, 96'(poe), 96'(e_oe[k]));
    if (!rst) begin
      if (m_t[k] < 0) begin
        e_ack[k] = '0;
        e_err[k] = '0;
        if (k == 1) m_ptr[k] = (m_win[k] + 1) % nreq(k);
        m_t[k] = 0;
      end else if (m_t[k] == 0) begin
        if (rq != 3'b000) begin
          int s;
          int w;
          s = (k == 1) ? m_ptr[k] : 0;
          w = -1;
          for (int j = 0; j < nreq(k); j++) begin
            int i;
            i = (s + j) % nreq(k);
            if (w < 0 && rq[i]) w = i;
          end
          m_win[k] = w;
          e_str[k] = 1'b1;
          e_prw[k] = (rw[2*w +: 2] == 2'b10) ? 2'b10 : 2'b01;
          e_oe[k]  = (rw[2*w +: 2] == 2'b10);
          e_f3[k]  = f3[3*w +: 3];
          e_ad[k]  = ad[16*w +: 16];
          e_wd[k]  = wd[32*w +: 32];
          m_t[k]   = 1;
        end
      end else if (m_t[k] == 1) begin
        e_str[k] = 1'b0;
        m_t[k]   = 2;
      end else begin
        bit done;
        bit tmo;
        done = 1'b0;
        tmo  = 1'b0;
        if (prdy) begin
          done = 1'b1;
          if (e_prw[k] == 2'b01) e_rd[k] = prd;
        end else if (m_t[k] - 1 == TO) begin
          done = 1'b1;
          tmo  = 1'b1;
        end else begin
          m_t[k]++;
        end
        if (done) begin
          e_ack[k] = 3'(1 << m_win[k]);
          e_err[k] = tmo ? 3'(1 << m_win[k]) : 3'b000;
          e_prw[k] = 2'b00;
          e_oe[k]  = 1'b0;
          m_t[k]   = -1;
        end
      end
    end
  endtask

  // compare both DUTs against the model every cycle
  always @(negedge clk) begin
    step(0, {1'b0, r0}, {2'b0, rw0}, {3'b0, f30}, {16'b0, ad0},
         {32'b0, wd0}, {1'b0, ack0}, {1'b0, err0}, {1'b0, st0}, rd0,
         pst0, prw0, pf0, pa0, pw0, poe0);
    step(1, r1, rw1, f31, ad1, wd1, ack1, err1, st1, rd1,
         pst1, prw1, pf1, pa1, pw1, poe1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int idx_of(input logic [2:0] a);
    for (int i = 0; i < 3; i++) if (a[i]) return i;
    return -1;
  endfunction

  task automatic wait_ack(input int k, input int budget,
                          output int cyc, output int idx);
    cyc = 0;
    idx = -1;
    while (cyc < budget) begin
      tick();
      cyc++;
      if (k == 0 && ack0 != 2'b00) begin
        idx = idx_of({1'b0, ack0});
        return;
      end
      if (k == 1 && ack1 != 3'b000) begin
        idx = idx_of(ack1);
        return;
      end
    end
    checks++;
    errors++;
    $display("FAIL wait_ack%0d no ack within %0d cycles", k, budget);
  endtask

  int c;
  int g;
  int rr_exp[6] = '{0, 1, 2, 0, 1, 2};

  initial begin
    rst = 1'b1; prdy = 1'b0; prd = '0;
    r0 = '0; rw0 = '0; f30 = '0; ad0 = '0; wd0 = '0;
    r1 = '0; rw1 = '0; f31 = '0; ad1 = '0; wd1 = '0;
    tick(); tick();
    chk("rst.PStrobe", 96'(pst0), 96'(0));
    chk("rst.PRW", 96'(prw0), 96'(0));
    chk("rst.ack", 96'(ack1), 96'(0));
    rst = 1'b0;
    tick();

    // single read, rw=00 treated as read, req dropped mid-transaction
    rw0[1:0] = 2'b00; f30[2:0] = 3'b101; ad0[15:0] = 16'h0040;
    prdy = 1'b1; prd = 32'hDEADBEEF; r0 = 2'b01;
    tick();
    chk("t1.PStrobe", 96'(pst0), 96'(1));
    chk("t1.PRW", 96'(prw0), 96'(2'b01));
    chk("t1.PAddress", 96'(pa0), 96'(16'h0040));
    chk("t1.PF3", 96'(pf0), 96'(3'b101));
    tick();
    r0 = 2'b00;
    tick();
    chk("t1.ack", 96'(ack0), 96'(2'b01));
    chk("t1.rdata", 96'(rd0), 96'(32'hDEADBEEF));
    tick();

    // write from requester 1 with 4 wait cycles
    prdy = 1'b0; rw0[3:2] = 2'b10; wd0[63:32] = 32'h12345678;
    ad0[31:16] = 16'h0100; r0 = 2'b10;
    tick();
    chk("t2.PDataOE.s", 96'(poe0), 96'(1));
    tick();
    chk("t2.PWData", 96'(pw0), 96'(32'h12345678));
    chk("t2.PRW", 96'(prw0), 96'(2'b10));
    ad0[31:16] = 16'hFFFF;
    tick(); tick(); tick();
    chk("t2.PDataOE.w", 96'(poe0), 96'(1));
    chk("t2.PAddress", 96'(pa0), 96'(16'h0100));
    prdy = 1'b1;
    tick();
    chk("t2.ack", 96'(ack0), 96'(2'b10));
    chk("t2.err", 96'(err0), 96'(2'b00));
    chk("t2.rdata", 96'(rd0), 96'(32'hDEADBEEF));
    r0 = 2'b00; prdy = 1'b0;
    tick();

    // fixed priority, both requesting
    ad0[31:16] = 16'h0200; rw0 = 4'b0101;
    prd = 32'hA5A50001; prdy = 1'b1; r0 = 2'b11;
    for (int i = 0; i < 4; i++) begin
      wait_ack(0, 20, c, g);
      chk("t3.grant", 96'(g), 96'(0));
      chk("t3.spacing", 96'(c), 96'((i == 0) ? 3 : 4));
    end
    r0 = 2'b00;
    tick();

    // timeout, then a normal read
    prdy = 1'b0; prd = 32'h0BADF00D; r0 = 2'b01;
    wait_ack(0, 30, c, g);
    chk("t5.latency", 96'(c), 96'(10));
    chk("t5.err", 96'(err0), 96'(2'b01));
    chk("t5.rdata", 96'(rd0), 96'(32'hA5A50001));
    r0 = 2'b00;
    tick();
    prdy = 1'b1; prd = 32'h00001111; r0 = 2'b01;
    wait_ack(0, 20, c, g);
    chk("t5b.latency", 96'(c), 96'(3));
    chk("t5b.err", 96'(err0), 96'(2'b00));
    chk("t5b.rdata", 96'(rd0), 96'(32'h00001111));
    r0 = 2'b00;
    tick();

    // round-robin over three requesters
    rw1 = 6'b010101; ad1 = {16'h3000, 16'h2000, 16'h1000};
    f31 = {3'b011, 3'b010, 3'b001}; prdy = 1'b1; r1 = 3'b111;
    for (int i = 0; i < 6; i++) begin
      wait_ack(1, 20, c, g);
      chk("t4.grant", 96'(g), 96'(rr_exp[i]));
    end
    r1 = 3'b000;
    tick();

    // advance pointer, then reset during the second wait cycle
    r1 = 3'b001;
    wait_ack(1, 20, c, g);
    chk("t6.pre", 96'(g), 96'(0));
    r1 = 3'b000;
    tick();
    prdy = 1'b0; rw1[3:2] = 2'b10; wd1[63:32] = 32'hCAFEF00D;
    r1 = 3'b010;
    tick(); tick(); tick();
    chk("t6.oe.before", 96'(poe1), 96'(1));
    rst = 1'b1;
    #1;
    chk("t6.PStrobe", 96'(pst1), 96'(0));
    chk("t6.PRW", 96'(prw1), 96'(0));
    chk("t6.PDataOE", 96'(poe1), 96'(0));
    chk("t6.ack", 96'(ack1), 96'(0));
    r1 = 3'b000;
    tick(); tick();
    rst = 1'b0; prdy = 1'b1; r1 = 3'b111;
    wait_ack(1, 20, c, g);
    chk("t6.grant", 96'(g), 96'(0));
    chk("t6.latency", 96'(c), 96'(3));
    r1 = 3'b000;
    tick(); tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
